// File: rtl/alu_pkg.sv
// Shared constants for the ALU execute stage: opcodes, condition codes,
// flag bit positions and the stage FSM encoding.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
      OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
      OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
      OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
   } opcode_e;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_execute_stage_if.sv
// Issue and write-back bundle between decode/register bank and the execute stage.
interface alu_execute_stage_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 4
);
   logic              i_valid;
   logic              o_ready;
   logic [3:0]        i_opcode;
   logic              i_mul;
   logic              i_set_flags;
   logic [3:0]        i_cond;
   logic [ADDR_W-1:0] i_dest;
   logic [WIDTH-1:0]  i_op1;
   logic [WIDTH-1:0]  i_op2;
   logic              o_wb_valid;
   logic [ADDR_W-1:0] o_wb_dest;
   logic [WIDTH-1:0]  o_wb_data;
   logic [3:0]        o_flags;

   modport master (
      output i_valid, i_opcode, i_mul, i_set_flags, i_cond, i_dest, i_op1, i_op2,
      input  o_ready, o_wb_valid, o_wb_dest, o_wb_data, o_flags
   );

   modport slave (
      input  i_valid, i_opcode, i_mul, i_set_flags, i_cond, i_dest, i_op1, i_op2,
      output o_ready, o_wb_valid, o_wb_dest, o_wb_data, o_flags
   );
endinterface

// File: rtl/alu_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks.
// o_done/o_product describe the final iteration, which completes at the next edge.
module alu_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_op_a,
   input  logic [WIDTH-1:0] i_op_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);
   localparam int CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic [WIDTH-1:0] w_acc_next;

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});
   assign o_busy     = r_busy;
   assign o_done     = r_busy & (r_cnt == CNT_W'(WIDTH - 1));
   assign o_product  = w_acc_next;

   // Load operands on start, then accumulate one bit of the multiplier per edge
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_acc    <= {WIDTH{1'b0}};
         r_mcand  <= {WIDTH{1'b0}};
         r_mplier <= {WIDTH{1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
         r_busy   <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_acc    <= {WIDTH{1'b0}};
         r_mcand  <= i_op_a;
         r_mplier <= i_op_b;
         r_cnt    <= {CNT_W{1'b0}};
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CNT_W'(1);
         r_busy   <= ~o_done;
      end
   end
endmodule

// File: rtl/alu_execute_stage.sv
// ARM execute stage: condition check, single-cycle data-processing ALU,
// iterative MUL, NZCV flags and the registered write-back triple.
module alu_execute_stage
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   alu_execute_stage_if.slave bus
);
   state_e            r_state;
   logic              r_wb_valid;
   logic [ADDR_W-1:0] r_wb_dest;
   logic [WIDTH-1:0]  r_wb_data;
   logic [3:0]        r_flags;
   logic [ADDR_W-1:0] r_mul_dest;
   logic              r_mul_s;

   logic [WIDTH-1:0]  w_a;
   logic [WIDTH-1:0]  w_b;
   logic              w_cin;
   logic              w_arith;
   logic [WIDTH-1:0]  w_logic;
   logic [WIDTH:0]    w_sum;
   logic [WIDTH-1:0]  w_result;
   logic [3:0]        w_new_flags;
   logic              w_cmp_only;
   logic              w_exec;
   logic              w_mul_busy;
   logic              w_mul_done;
   logic [WIDTH-1:0]  w_product;

   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      n  = f[FLAG_N];
      z  = f[FLAG_Z];
      cf = f[FLAG_C];
      v  = f[FLAG_V];
      case (c)
         COND_EQ: cond_pass = z;
         COND_NE: cond_pass = ~z;
         COND_CS: cond_pass = cf;
         COND_CC: cond_pass = ~cf;
         COND_MI: cond_pass = n;
         COND_PL: cond_pass = ~n;
         COND_VS: cond_pass = v;
         COND_VC: cond_pass = ~v;
         COND_HI: cond_pass = cf & ~z;
         COND_LS: cond_pass = ~cf | z;
         COND_GE: cond_pass = (n == v);
         COND_LT: cond_pass = (n != v);
         COND_GT: cond_pass = ~z & (n == v);
         COND_LE: cond_pass = z | (n != v);
         COND_AL: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   assign bus.o_ready    = (r_state == ST_IDLE) & ~w_mul_busy & ~Reset;
   assign bus.o_wb_valid = r_wb_valid;
   assign bus.o_wb_dest  = r_wb_dest;
   assign bus.o_wb_data  = r_wb_data;
   assign bus.o_flags    = r_flags;

   assign w_exec     = bus.i_valid & bus.o_ready & cond_pass(bus.i_cond, r_flags);
   assign w_cmp_only = (bus.i_opcode[3:2] == 2'b10);

   // Subtracts feed the adder with an inverted operand so C comes out as NOT borrow
   always_comb begin
      w_a     = bus.i_op1;
      w_b     = bus.i_op2;
      w_cin   = 1'b0;
      w_arith = 1'b1;
      w_logic = {WIDTH{1'b0}};
      case (bus.i_opcode)
         OP_AND, OP_TST: begin w_arith = 1'b0; w_logic = bus.i_op1 & bus.i_op2;  end
         OP_EOR, OP_TEQ: begin w_arith = 1'b0; w_logic = bus.i_op1 ^ bus.i_op2;  end
         OP_SUB, OP_CMP: begin w_b = ~bus.i_op2; w_cin = 1'b1; end
         OP_RSB:         begin w_a = bus.i_op2; w_b = ~bus.i_op1; w_cin = 1'b1; end
         OP_ADD, OP_CMN: begin w_cin = 1'b0; end
         OP_ADC:         begin w_cin = r_flags[FLAG_C]; end
         OP_SBC:         begin w_b = ~bus.i_op2; w_cin = r_flags[FLAG_C]; end
         OP_RSC:         begin w_a = bus.i_op2; w_b = ~bus.i_op1; w_cin = r_flags[FLAG_C]; end
         OP_ORR:         begin w_arith = 1'b0; w_logic = bus.i_op1 | bus.i_op2;  end
         OP_MOV:         begin w_arith = 1'b0; w_logic = bus.i_op2;              end
         OP_BIC:         begin w_arith = 1'b0; w_logic = bus.i_op1 & ~bus.i_op2; end
         OP_MVN:         begin w_arith = 1'b0; w_logic = ~bus.i_op2;             end
         default:        begin w_arith = 1'b0; w_logic = {WIDTH{1'b0}};          end
      endcase
   end

   assign w_sum    = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
   assign w_result = w_arith ? w_sum[WIDTH-1:0] : w_logic;

   // Logical ops leave C and V alone because there is no shifter carry
   always_comb begin
      w_new_flags         = r_flags;
      w_new_flags[FLAG_N] = w_result[WIDTH-1];
      w_new_flags[FLAG_Z] = (w_result == {WIDTH{1'b0}});
      w_new_flags[FLAG_C] = w_arith ? w_sum[WIDTH] : r_flags[FLAG_C];
      w_new_flags[FLAG_V] = w_arith ? ((w_a[WIDTH-1] == w_b[WIDTH-1]) &
                                       (w_sum[WIDTH-1] != w_a[WIDTH-1]))
                                    : r_flags[FLAG_V];
   end

   alu_multiplier #(.WIDTH(WIDTH)) u_mul (
      .Clk       (Clk),
      .Reset     (Reset),
      .i_start   (w_exec & bus.i_mul),
      .i_op_a    (bus.i_op1),
      .i_op_b    (bus.i_op2),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );

   // Stage FSM, flags register and write-back registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= ST_IDLE;
         r_wb_valid <= 1'b0;
         r_wb_dest  <= {ADDR_W{1'b0}};
         r_wb_data  <= {WIDTH{1'b0}};
         r_flags    <= 4'b0000;
         r_mul_dest <= {ADDR_W{1'b0}};
         r_mul_s    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_wb_valid <= 1'b0;
               if (w_exec && bus.i_mul) begin
                  r_state    <= ST_MUL;
                  r_mul_dest <= bus.i_dest;
                  r_mul_s    <= bus.i_set_flags;
               end else if (w_exec) begin
                  if (!w_cmp_only) begin
                     r_wb_valid <= 1'b1;
                     r_wb_dest  <= bus.i_dest;
                     r_wb_data  <= w_result;
                  end
                  if (bus.i_set_flags || w_cmp_only) begin
                     r_flags <= w_new_flags;
                  end
               end
            end
            ST_MUL: begin
               r_wb_valid <= 1'b0;
               if (w_mul_done) begin
                  r_state    <= ST_IDLE;
                  r_wb_valid <= 1'b1;
                  r_wb_dest  <= r_mul_dest;
                  r_wb_data  <= w_product;
                  if (r_mul_s) begin
                     r_flags[FLAG_N] <= w_product[WIDTH-1];
                     r_flags[FLAG_Z] <= (w_product == {WIDTH{1'b0}});
                  end
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_wb_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_execute_stage.sv
// Scoreboard bench for alu_execute_stage: expected write-backs are queued at
// issue time and popped by a monitor when o_wb_valid appears.
module tb_alu_execute_stage;
   import alu_pkg::*;

   typedef struct {
      logic [3:0]  dest;
      logic [31:0] data;
   } wb_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   logic [3:0] m_flags;
   wb_t  sb_q[$];

   alu_execute_stage_if #(.WIDTH(32), .ADDR_W(4)) bus ();

   alu_execute_stage #(.WIDTH(32), .ADDR_W(4)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cf;
         4'h3: return !cf;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cf && !z;
         4'h9: return !cf || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Reference data-processing model using 64-bit integer arithmetic
   function automatic void ref_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] fin, input logic s,
                                    output logic wb, output logic [31:0] r, output logic [3:0] fout);
      longint ua, ub, sa, sb, val, ci, nci;
      logic   arith, cc, vv;
      ua = {32'd0, a};
      ub = {32'd0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ci  = fin[1] ? 64'sd1 : 64'sd0;
      nci = fin[1] ? 64'sd0 : 64'sd1;
      arith = 1'b1; cc = 1'b0; val = 64'sd0; r = 32'd0;
      case (op)
         4'h0, 4'h8: begin arith = 1'b0; r = a & b; end
         4'h1, 4'h9: begin arith = 1'b0; r = a ^ b; end
         4'h2, 4'hA: begin cc = (ua >= ub);       val = sa - sb; end
         4'h3:       begin cc = (ub >= ua);       val = sb - sa; end
         4'h4, 4'hB: begin cc = ((ua + ub) >>> 32) != 64'sd0;      val = sa + sb; end
         4'h5:       begin cc = ((ua + ub + ci) >>> 32) != 64'sd0; val = sa + sb + ci; end
         4'h6:       begin cc = (ua >= ub + nci); val = sa - sb - nci; end
         4'h7:       begin cc = (ub >= ua + nci); val = sb - sa - nci; end
         4'hC:       begin arith = 1'b0; r = a | b; end
         4'hD:       begin arith = 1'b0; r = b; end
         4'hE:       begin arith = 1'b0; r = a & ~b; end
         default:    begin arith = 1'b0; r = ~b; end
      endcase
      if (arith) r = val[31:0];
      vv = (val != longint'($signed(val[31:0])));
      wb = (op[3:2] != 2'b10);
      fout = fin;
      if (s || !wb) begin
         fout[3] = r[31];
         fout[2] = (r == 32'd0);
         if (arith) begin
            fout[1] = cc;
            fout[0] = vv;
         end
      end
   endfunction

   // Scoreboard monitor: every write-back strobe must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && bus.o_wb_valid === 1'b1) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            $display("FAIL wb_unexpected: got dest=%0d data=%h, required no write-back",
                     bus.o_wb_dest, bus.o_wb_data);
         end else begin
            wb_t e;
            e = sb_q.pop_front();
            if (bus.o_wb_dest !== e.dest || bus.o_wb_data !== e.data)
               $display("FAIL wb_data: got dest=%0d data=%h, required dest=%0d data=%h",
                        bus.o_wb_dest, bus.o_wb_data, e.dest, e.data);
            else
               n_pass++;
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic mul, input logic s, input logic [3:0] cond,
                        input logic [3:0] dest, input logic [31:0] a, input logic [31:0] b);
      logic pass, wb;
      logic [31:0] r, prod;
      logic [3:0]  f;
      n_checks++;
      if (bus.o_ready !== 1'b1)
         $display("FAIL issue_ready: got o_ready=%b, required 1", bus.o_ready);
      else
         n_pass++;
      pass = cond_ok(cond, m_flags);
      if (pass && !mul) begin
         ref_exec(op, a, b, m_flags, s, wb, r, f);
         if (wb) sb_q.push_back('{dest, r});
         m_flags = f;
      end else if (pass && mul) begin
         prod = a * b;
         sb_q.push_back('{dest, prod});
         if (s) begin
            m_flags[3] = prod[31];
            m_flags[2] = (prod == 32'd0);
         end
      end
      bus.i_valid = 1'b1; bus.i_opcode = op; bus.i_mul = mul; bus.i_set_flags = s;
      bus.i_cond = cond; bus.i_dest = dest; bus.i_op1 = a; bus.i_op2 = b;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      if (!(mul && pass)) begin
         n_checks++;
         if (bus.o_flags !== m_flags)
            $display("FAIL issue_flags: got %b, required %b", bus.o_flags, m_flags);
         else
            n_pass++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.o_wb_valid !== 1'b0 || bus.o_wb_dest !== 4'd0 || bus.o_wb_data !== 32'd0 ||
          bus.o_flags !== 4'b0000 || bus.o_ready !== 1'b0)
         $display("FAIL reset_state: got v=%b d=%0d data=%h f=%b rdy=%b, required 0 0 0 0000 0",
                  bus.o_wb_valid, bus.o_wb_dest, bus.o_wb_data, bus.o_flags, bus.o_ready);
      else
         n_pass++;
      rst = 1'b0;
      m_flags = 4'b0000;
      #1;
      n_checks++;
      if (bus.o_ready !== 1'b1)
         $display("FAIL reset_ready: got o_ready=%b, required 1", bus.o_ready);
      else
         n_pass++;
   endtask

   task automatic test_back_to_back();
      issue(4'h4, 1'b0, 1'b1, 4'hE, 4'd3, 32'h7FFFFFFF, 32'h00000001);
      n_checks++;
      if (bus.o_wb_valid !== 1'b1 || bus.o_flags !== 4'b1001)
         $display("FAIL add_ovf: got v=%b f=%b, required v=1 f=1001", bus.o_wb_valid, bus.o_flags);
      else
         n_pass++;
      issue(4'h2, 1'b0, 1'b1, 4'hE, 4'd4, 32'h00000000, 32'h00000001);
      n_checks++;
      if (bus.o_wb_valid !== 1'b1 || bus.o_flags !== 4'b1000)
         $display("FAIL sub_neg: got v=%b f=%b, required v=1 f=1000", bus.o_wb_valid, bus.o_flags);
      else
         n_pass++;
      issue(4'h5, 1'b0, 1'b1, 4'hE, 4'd5, 32'hFFFFFFFF, 32'h00000000);
      n_checks++;
      if (bus.o_wb_valid !== 1'b1 || bus.o_wb_data !== 32'hFFFFFFFF || bus.o_flags !== 4'b1000)
         $display("FAIL adc_c0: got v=%b data=%h f=%b, required v=1 data=ffffffff f=1000",
                  bus.o_wb_valid, bus.o_wb_data, bus.o_flags);
      else
         n_pass++;
   endtask

   task automatic test_cmp_cond();
      issue(4'hA, 1'b0, 1'b0, 4'hE, 4'd0, 32'd5, 32'd5);
      n_checks++;
      if (bus.o_wb_valid !== 1'b0 || bus.o_flags !== 4'b0110)
         $display("FAIL cmp_eq: got v=%b f=%b, required v=0 f=0110", bus.o_wb_valid, bus.o_flags);
      else
         n_pass++;
      issue(4'h4, 1'b0, 1'b0, 4'h0, 4'd1, 32'd2, 32'd2);
      n_checks++;
      if (bus.o_wb_valid !== 1'b1 || bus.o_wb_dest !== 4'd1 || bus.o_wb_data !== 32'd4)
         $display("FAIL add_eq: got v=%b d=%0d data=%h, required v=1 d=1 data=4",
                  bus.o_wb_valid, bus.o_wb_dest, bus.o_wb_data);
      else
         n_pass++;
      issue(4'h4, 1'b0, 1'b1, 4'h1, 4'd2, 32'd9, 32'd9);
      n_checks++;
      if (bus.o_wb_valid !== 1'b0 || bus.o_flags !== 4'b0110)
         $display("FAIL add_ne: got v=%b f=%b, required v=0 f=0110", bus.o_wb_valid, bus.o_flags);
      else
         n_pass++;
   endtask

   task automatic test_mul();
      int   cyc;
      logic ready_ok;
      issue(4'h0, 1'b1, 1'b1, 4'hE, 4'd7, 32'h0000AAAA, 32'h00010001);
      bus.i_valid = 1'b1; bus.i_mul = 1'b0; bus.i_opcode = 4'h4; bus.i_dest = 4'd2;
      bus.i_cond = 4'hE;  bus.i_op1 = 32'h11; bus.i_op2 = 32'h22;
      cyc = 0;
      ready_ok = 1'b1;
      while (bus.o_wb_valid !== 1'b1 && cyc < 40) begin
         if (bus.o_ready !== 1'b0) ready_ok = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      bus.i_valid = 1'b0;
      n_checks++;
      if (cyc != 32) $display("FAIL mul_latency: got %0d edges, required 32", cyc);
      else n_pass++;
      n_checks++;
      if (!ready_ok || bus.o_ready !== 1'b1)
         $display("FAIL mul_ready: got busy_low_ok=%b ready_after=%b, required 1 1", ready_ok, bus.o_ready);
      else
         n_pass++;
      n_checks++;
      if (bus.o_wb_data !== 32'hAAAAAAAA || bus.o_wb_dest !== 4'd7 || bus.o_flags !== 4'b1010)
         $display("FAIL mul_result: got d=%0d data=%h f=%b, required d=7 data=aaaaaaaa f=1010",
                  bus.o_wb_dest, bus.o_wb_data, bus.o_flags);
      else
         n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_mul_reset();
      int seen;
      issue(4'h0, 1'b1, 1'b1, 4'hE, 4'd9, 32'h00001234, 32'h00005678);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      sb_q.delete();
      m_flags = 4'b0000;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.o_ready !== 1'b1 || bus.o_flags !== 4'b0000)
         $display("FAIL mul_abort_state: got rdy=%b f=%b, required 1 0000", bus.o_ready, bus.o_flags);
      else
         n_pass++;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.o_wb_valid === 1'b1) seen++;
      end
      n_checks++;
      if (seen != 0) $display("FAIL mul_abort_wb: got %0d strobes, required 0", seen);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_nv_mul();
      issue(4'h0, 1'b1, 1'b1, 4'hF, 4'd6, 32'd3, 32'd4);
      issue(4'h4, 1'b0, 1'b0, 4'hE, 4'd8, 32'd10, 32'd20);
      n_checks++;
      if (bus.o_wb_valid !== 1'b1 || bus.o_wb_dest !== 4'd8 || bus.o_wb_data !== 32'd30)
         $display("FAIL nv_mul_then_add: got v=%b d=%0d data=%h, required v=1 d=8 data=1e",
                  bus.o_wb_valid, bus.o_wb_dest, bus.o_wb_data);
      else
         n_pass++;
   endtask

   task automatic test_alu_random();
      logic [31:0] a, b;
      for (int i = 0; i < 48; i++) begin
         a = $urandom;
         b = (i % 5 == 0) ? a : $urandom;
         if (i % 7 == 3) b = ~a;
         issue(4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), a, b);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      m_flags  = 4'b0000;
      rst      = 1'b1;
      bus.i_valid = 1'b0; bus.i_opcode = 4'h0; bus.i_mul = 1'b0; bus.i_set_flags = 1'b0;
      bus.i_cond  = 4'hE; bus.i_dest = 4'd0;   bus.i_op1 = 32'd0; bus.i_op2 = 32'd0;
      test_reset();
      test_back_to_back();
      test_cmp_cond();
      test_mul();
      test_mul_reset();
      test_nv_mul();
      test_alu_random();
      n_checks++;
      if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending, required 0", sb_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
